// File: rtl/des_final_permutation_tx.sv
// DES output stage: forms R16||L16, applies IP^-1 and streams the ciphertext as OUT_W-bit beats.
// Define DES_FP_HOLD_EN to add a one-block holding register so blocks can stream back to back.
module des_final_permutation_tx #(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      l16,
    input  logic [31:0]      r16,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    localparam int               BEATS     = 64 / OUT_W;
    localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    // IP^-1: ciphertext bit i+1 takes preoutput bit FP_TABLE[i] (1-based DES numbering).
    localparam int FP_TABLE [64] = '{
        40,  8, 48, 16, 56, 24, 64, 32,
        39,  7, 47, 15, 55, 23, 63, 31,
        38,  6, 46, 14, 54, 22, 62, 30,
        37,  5, 45, 13, 53, 21, 61, 29,
        36,  4, 44, 12, 52, 20, 60, 28,
        35,  3, 43, 11, 51, 19, 59, 27,
        34,  2, 42, 10, 50, 18, 58, 26,
        33,  1, 41,  9, 49, 17, 57, 25
    };

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic logic [63:0] final_perm(input logic [63:0] pre_in);
        logic [63:0] perm;
        for (int i = 0; i < 64; i++) begin
            perm[i] = pre_in[FP_TABLE[i] - 1];
        end
        return perm;
    endfunction

    state_t           state_q, state_d;
    logic [63:0]      shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pre_out;
    logic [63:0]      ct_perm;
    logic             hold_full;
    logic             in_fire;
    logic             out_fire;
    logic             last_beat;

    // The 32-bit swap undoes the swap performed at the end of round 16.
    assign pre_out   = {l16, r16};
    assign ct_perm   = final_perm(pre_out);

    assign out_valid = (state_q == SEND);
    assign out_data  = shift_q[OUT_W-1:0];
    assign last_beat = (cnt_q == LAST_BEAT);
    assign out_last  = out_valid && last_beat;
    assign busy      = out_valid | hold_full;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

`ifdef DES_FP_HOLD_EN
    logic [63:0] hold_q, hold_d;
    logic        hold_full_q, hold_full_d;

    assign hold_full = hold_full_q;
    assign in_ready  = !hold_full_q;
`else
    assign hold_full = 1'b0;
    assign in_ready  = (state_q == IDLE);
`endif

    always_comb begin
        // NOTE: every _d takes its current value first, so no branch can leave a latch behind.
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
`ifdef DES_FP_HOLD_EN
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    shift_d = ct_perm;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_fire) begin
                    if (last_beat) begin
                        cnt_d = '0;
`ifdef DES_FP_HOLD_EN
                        if (hold_full_q) begin
                            shift_d     = hold_q;
                            hold_full_d = 1'b0;
                        end else begin
                            shift_d = shift_q >> OUT_W;
                            state_d = IDLE;
                        end
`else
                        shift_d = shift_q >> OUT_W;
                        state_d = IDLE;
`endif
                    end else begin
                        shift_d = shift_q >> OUT_W;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
`ifdef DES_FP_HOLD_EN
                // A same-edge accept refills hold after the handoff above emptied it.
                if (in_fire) begin
                    hold_d      = ct_perm;
                    hold_full_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef DES_FP_HOLD_EN
    // NOTE: hold data is cleared with its flag so a block discarded by reset never resurfaces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end
`endif

endmodule

// File: tb/tb_des_final_permutation_tx.sv
// Directed bench for des_final_permutation_tx: FIPS vector, backpressure, IP round trip,
// mid-block reset, 64-bit beat width and (with DES_FP_HOLD_EN) back-to-back streaming.
module tb_des_final_permutation_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] l16, r16;
    logic        out_valid, out_ready, out_last, busy;
    logic [7:0]  out_data;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_last, w_busy;
    logic [63:0] w_out_data;

    int checks   = 0;
    int failures = 0;

    int ip_tab [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,
        60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,
        64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,
        59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,
        63, 55, 47, 39, 31, 23, 15, 7
    };

    always #5 clk = ~clk;

    des_final_permutation_tx #(.OUT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .l16(l16), .r16(r16),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy)
    );

    des_final_permutation_tx #(.OUT_W(64)) dut_w64 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .l16(l16), .r16(r16),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .out_last(w_out_last), .busy(w_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    function automatic logic [31:0] rev32(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = x[31-i];
        return r;
    endfunction

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    // Forward initial permutation; FP(IP(x)) must give x back.
    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[ip_tab[i] - 1];
        return r;
    endfunction

    // Called at a falling edge; returns at the falling edge after the accepting rising edge.
    task automatic send_block(input logic [31:0] l, input logic [31:0] r);
        int cyc;
        cyc      = 0;
        in_valid = 1'b1;
        l16      = l;
        r16      = r;
        while (!in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic collect_block(input bit stall_mode, output logic [63:0] data);
        int         k, cyc, wait_cyc;
        bit         stalled;
        logic [7:0] held_data;
        logic       held_last;
        k = 0; cyc = 0; wait_cyc = 0; stalled = 1'b0;
        held_data = '0; held_last = 1'b0; data = '0;
        while (!out_valid && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        while (k < 8 && cyc < 200) begin
            out_ready = stall_mode ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (stalled) begin
                check("stall_data", 64'(out_data), 64'(held_data));
                check("stall_last", 64'(out_last), 64'(held_last));
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                data[8*k +: 8] = out_data;
                check("beat_last", 64'(out_last), 64'(k == 7));
                k++;
            end else if (out_valid) begin
                stalled   = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        if (k != 8) check("collect_beats", 64'(k), 64'd8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got, x, y, exp_ct, fips_ct;
        logic [31:0] fl, fr;
        in_valid = 1'b0; out_ready = 1'b0; w_in_valid = 1'b0; w_out_ready = 1'b0;
        l16 = '0; r16 = '0; rst_n = 1'b0;

        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_w64_last",  64'(w_out_last), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        check("post_rst_ready", 64'(in_ready),  64'd1);

        // FIPS vector: values are in FIPS notation and bit-mapped onto vector indices.
        fl      = rev32(32'h43423234);
        fr      = rev32(32'h0A4CD995);
        fips_ct = 64'h85E813540F0AB405;
        exp_ct  = rev64(fips_ct);
        send_block(fl, fr);
        check("send_busy", 64'(busy), 64'd1);
`ifdef DES_FP_HOLD_EN
        check("send_in_ready", 64'(in_ready), 64'd1);
`else
        check("send_in_ready", 64'(in_ready), 64'd0);
`endif
        collect_block(1'b0, got);
        check("fips_ct", got, exp_ct);
        for (int k = 0; k < 8; k++) begin
            check("fips_beat", 64'(rev8(got[8*k +: 8])), 64'(fips_ct[8*(7-k) +: 8]));
        end
        check("fips_done_ready", 64'(in_ready),  64'd1);
        check("fips_done_valid", 64'(out_valid), 64'd0);
        check("fips_done_busy",  64'(busy),      64'd0);

        // Backpressure 1,0,0,1 on the FIPS vector and on a second block.
        send_block(fl, fr);
        collect_block(1'b1, got);
        check("bp_fips_ct", got, exp_ct);
        x = 64'hDEADBEEF_01234567;
        y = ip_perm(x);
        send_block(y[63:32], y[31:0]);
        collect_block(1'b1, got);
        check("bp_roundtrip", got, x);

`ifndef DES_FP_HOLD_EN
        // A request raised while busy must wait for IDLE and not disturb the block in flight.
        x = 64'h0F1E2D3C_4B5A6978;
        y = ip_perm(x);
        send_block(fl, fr);
        in_valid = 1'b1;
        l16 = y[63:32];
        r16 = y[31:0];
        collect_block(1'b0, got);
        check("ignore_busy_ct", got, exp_ct);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        collect_block(1'b0, got);
        check("ignore_next_ct", got, x);
`endif

        // Reset after beat 3 of 8 discards the block.
        x = 64'h1122334455667788;
        y = ip_perm(x);
        send_block(y[63:32], y[31:0]);
        for (int k = 0; k < 4; k++) begin
            out_ready = 1'b1;
            check("rst_pre_beat", 64'(out_data), 64'(x[8*k +: 8]));
            @(negedge clk);
        end
        out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy",  64'(busy),      64'd0);
        check("mid_rst_ready", 64'(in_ready),  64'd1);
        check("mid_rst_data",  64'(out_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_valid", 64'(out_valid), 64'd0);
        x = 64'hA5A5F00F_3C3CC33C;
        y = ip_perm(x);
        send_block(y[63:32], y[31:0]);
        collect_block(1'b0, got);
        check("after_rst_block", got, x);

        // 64-bit beat width: single beat, one cycle after accept.
        l16 = fl;
        r16 = fr;
        w_in_valid = 1'b1;
        check("w64_in_ready", 64'(w_in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        w_in_valid = 1'b0;
        check("w64_valid", 64'(w_out_valid), 64'd1);
        check("w64_last",  64'(w_out_last),  64'd1);
        check("w64_data",  w_out_data,       exp_ct);
        check("w64_busy",  64'(w_busy),      64'd1);
        w_out_ready = 1'b1;
        @(negedge clk);
        w_out_ready = 1'b0;
        check("w64_done_valid", 64'(w_out_valid), 64'd0);
        check("w64_done_ready", 64'(w_in_ready),  64'd1);

        // Round trip: FP(IP(x)) == x.
        for (int i = 0; i < 1000; i++) begin
            x = {$urandom, $urandom};
            y = ip_perm(x);
            send_block(y[63:32], y[31:0]);
            collect_block(i % 5 == 0, got);
            check("roundtrip", got, x);
        end

`ifdef DES_FP_HOLD_EN
        begin
            logic [63:0] xa, xb, ya, yb, ga, gb;
            int          w;
            xa = 64'h0123456789ABCDEF;
            xb = 64'hFEDCBA9876543210;
            ya = ip_perm(xa);
            yb = ip_perm(xb);
            ga = '0;
            gb = '0;
            fork
                begin
                    send_block(ya[63:32], ya[31:0]);
                    send_block(yb[63:32], yb[31:0]);
                end
                begin
                    w = 0;
                    while (!out_valid && w < 50) begin
                        @(negedge clk);
                        w++;
                    end
                    for (int k = 0; k < 16; k++) begin
                        out_ready = 1'b1;
                        check("b2b_valid", 64'(out_valid), 64'd1);
                        check("b2b_last", 64'(out_last), 64'(k == 7 || k == 15));
                        check("b2b_in_ready", 64'(in_ready), 64'(!(k >= 1 && k <= 7)));
                        if (k < 8) ga[8*k +: 8] = out_data;
                        else       gb[8*(k-8) +: 8] = out_data;
                        @(negedge clk);
                    end
                    out_ready = 1'b0;
                    check("b2b_idle", 64'(out_valid), 64'd0);
                end
            join
            check("b2b_block_a", ga, xa);
            check("b2b_block_b", gb, xb);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_final_permutation_tx.md
Name: des_final_permutation_tx

Overview:
Output stage of the DES datapath. It accepts the round-16 halves (L16, R16) on a valid/ready handshake and forms the preoutput R16||L16. It applies the inverse initial permutation (IP^-1, the final permutation), registers the 64-bit ciphertext and serialises it onto a narrow output stream with valid/ready/last. It is the counterpart of the initial-permutation input stage.

Parameters:
OUT_W, 8, output beat width in bits; legal values 8, 16, 32, 64; BEATS = 64/OUT_W.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  l16/r16 valid
in_ready  output  1  block can accept a new l16/r16 pair
l16  input  32  round-16 left half; index 0 = DES bit 1 of L
r16  input  32  round-16 right half; index 0 = DES bit 1 of R
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts beat
out_data  output  OUT_W  current ciphertext beat
out_last  output  1  high on final beat of a block
busy  output  1  high while a block is held or being sent

Behaviour:
- Bit convention: vector index i = DES bit i+1, for all 64-bit and 32-bit values.
- Preoutput: pre[31:0] = r16, pre[63:32] = l16 (the 32-bit swap undoes the round-16 swap).
- Final permutation: ct[i] = pre[FP[i]-1], FP = standard FIPS 46 IP^-1 table (40,8,48,16,56,24,64,32,39,7,...,25). Examples: ct[0]=pre[39], ct[1]=pre[7], ct[63]=pre[24].
- FP(IP(x)) = x for all x; the bench checks this.
- FSM states: IDLE, SEND.
- IDLE: in_ready=1. On in_valid&&in_ready, shift_reg <= ct, beat_cnt <= 0, next state SEND.
- SEND: out_valid=1. out_data = shift_reg[OUT_W-1:0], i.e. beat k = ct[OUT_W*k+OUT_W-1 : OUT_W*k], beat 0 first.
- SEND, on out_valid&&out_ready: shift_reg >>= OUT_W and beat_cnt++.
- out_last = (beat_cnt == BEATS-1). On the last accepted beat, return to IDLE (no hold buffer).
- out_data and out_last are held stable while out_valid && !out_ready.
- Latency: handshake accepted at edge N gives out_valid=1 after edge N. The minimum block period is BEATS+1 cycles without the hold buffer.
- beat_cnt width is clog2(BEATS) bits, minimum 1. For OUT_W=64, each block is a single beat with out_last=1.
- busy = (state==SEND) | hold_full.
- Reset values: state IDLE, out_valid 0, out_last 0, out_data 0, shift_reg 0, beat_cnt 0, busy 0, in_ready 1, hold_full 0.
- Reset asserted mid-block discards the block. No partial beat is emitted after rst_n deasserts.
- in_valid while in_ready=0 is ignored. The upstream must hold l16/r16 until accepted.

Optional Feature:
Macro DES_FP_HOLD_EN adds a one-entry holding register for a second permuted block.
- With the macro: in_ready = !hold_full, including during SEND. A block accepted in SEND is permuted into hold and hold_full is set.
- With the macro, on the last beat accepted with hold_full=1: shift_reg <= hold, hold_full clears, state stays SEND, beat_cnt <= 0. The next block's beat 0 appears the next cycle with no idle cycle.
- With the macro, an accept and a last-beat handoff on the same edge: the handoff is taken from the old hold and the new block loads hold; hold_full stays 1.
- Without the macro: in_ready = (state==IDLE), there is no hold register, and hold_full is tied to 0.

Test Plan:
- FIPS vector, OUT_W=8: r16=0A4CD995, l16=43423234 (FIPS notation, bench bit-maps DES bit n to index n-1). Required: 8 beats, after bit-mapping = 85,E8,13,54,0F,0A,B4,05; out_last only on beat 7; then in_ready=1.
- Backpressure: out_ready toggles in the pattern 1,0,0,1 repeating. Required: no beat dropped or duplicated, and out_data/out_last stable during stall cycles.
- Round trip: 1000 random 64-bit x; feed IP(x) split into l16=IP(x)[63:32] and r16=IP(x)[31:0] with halves swapped back. Required: the concatenated beats equal x.
- Reset mid-block: assert rst_n=0 after beat 3 of 8. Required: out_valid=0 immediately (asynchronous), busy=0, in_ready=1; the next block starts at beat 0.
- OUT_W=64: single beat equal to 85E813540F0AB405 (bit-mapped), out_last=1, one cycle after accept.
- DES_FP_HOLD_EN, back-to-back blocks with out_ready=1: 16 consecutive beats with no out_valid gap. Required: in_ready=0 only while hold_full.
